// File: rtl/clk_dec_unit.sv
// clk_dec_unit: clock buffer, even-ratio clock divider and 3-to-8 one-hot decoder.
// Optional build macro DEC_OUT_REG_EN: registers the decoder output (1-cycle latency).
module clk_dec_unit #(
    parameter int unsigned DIV_RATIO = 2
) (
    input  logic       clka,
    input  logic       rst_n,
    input  logic       E,
    input  logic [2:0] In,
    output logic [7:0] Out,
    output logic       clka_out,
    output logic       clkb_out
);

    localparam int unsigned HALF  = DIV_RATIO / 2;
    localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    // Reject odd or out-of-range ratios at elaboration
    if ((DIV_RATIO < 2) || (DIV_RATIO > 256) || ((DIV_RATIO % 2) != 0)) begin : g_bad_ratio
        $error("clk_dec_unit: DIV_RATIO must be an even value in 2..256");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clkb_q, clkb_d;
    logic [7:0]       dec_c;

    // Buffered clock copy, independent of reset
    assign clka_out = clka;

    // One AND term per output bit, so a bad select can never light two lines
    always_comb begin
        dec_c = 8'h00;
        for (int i = 0; i < 8; i++) begin
            dec_c[i] = E & (In == 3'(i));
        end
    end

    // Half-period counter: wrap and toggle the divided clock on the last count
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        clkb_d = clkb_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            clkb_d = ~clkb_q;
        end
    end

    // Divider state; reset truncates the divided clock immediately
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            clkb_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clkb_q <= clkb_d;
        end
    end

    assign clkb_out = clkb_q;

`ifdef DEC_OUT_REG_EN
    logic [7:0] out_q;

    // Registered decoder output for a glitch-free select bus
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 8'h00;
        end else begin
            out_q <= dec_c;
        end
    end

    assign Out = out_q;
`else
    assign Out = dec_c;
`endif

endmodule

// File: tb/tb_clk_dec_unit.sv
// Self-checking bench for clk_dec_unit: divider ratios 2/4/6 and the decoder.
module tb_clk_dec_unit;

    logic       clka;
    logic       rst_n;
    logic       E;
    logic [2:0] In;
    logic [7:0] out2, out4, out6;
    logic       ca2, ca4, ca6;
    logic       cb2, cb4, cb6;

    int total = 0;
    int bad   = 0;
    int n     = 0;     // rising edges seen with rst_n high since last reset

`ifdef DEC_OUT_REG_EN
    localparam bit REG_BUILD = 1'b1;
`else
    localparam bit REG_BUILD = 1'b0;
`endif

    clk_dec_unit #(.DIV_RATIO(2)) u_div2 (
        .clka(clka), .rst_n(rst_n), .E(E), .In(In),
        .Out(out2), .clka_out(ca2), .clkb_out(cb2)
    );
    clk_dec_unit #(.DIV_RATIO(4)) u_div4 (
        .clka(clka), .rst_n(rst_n), .E(E), .In(In),
        .Out(out4), .clka_out(ca4), .clkb_out(cb4)
    );
    clk_dec_unit #(.DIV_RATIO(6)) u_div6 (
        .clka(clka), .rst_n(rst_n), .E(E), .In(In),
        .Out(out6), .clka_out(ca6), .clkb_out(cb6)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Reference decode: a single bit at position In when enabled
    function automatic logic [7:0] dec_ref(input logic e, input logic [2:0] sel);
        return e ? 8'(1 << sel) : 8'h00;
    endfunction

    // Reference divided clock: toggles once every ratio/2 edges, starting low
    function automatic logic div_ref(input int ratio, input int edges);
        return ((edges / (ratio / 2)) % 2) == 1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clka cycle; check buffers around both edges and the dividers mid-low phase
    task automatic step();
        @(posedge clka);
        if (rst_n) n++;
        #1;
        chk("clka_out_hi", {5'd0, ca2, ca4, ca6}, 8'h07);
        @(negedge clka);
        #1;
        chk("clka_out_lo", {5'd0, ca2, ca4, ca6}, 8'h00);
        chk("clkb_div2", {7'd0, cb2}, {7'd0, div_ref(2, n)});
        chk("clkb_div4", {7'd0, cb4}, {7'd0, div_ref(4, n)});
        chk("clkb_div6", {7'd0, cb6}, {7'd0, div_ref(6, n)});
    endtask

    // Drive decoder inputs in the low phase and check the immediate Out value
    task automatic drive(input logic e, input logic [2:0] sel);
        logic [7:0] prev;
        prev = dec_ref(E, In);
        E  = e;
        In = sel;
        #1;
        chk("out_now", out2, REG_BUILD ? prev : dec_ref(e, sel));
        chk("out_now_u6", out6, REG_BUILD ? prev : dec_ref(e, sel));
    endtask

    initial begin
        int hi6;
        int rises6;
        logic prev6;
        int waited;

        rst_n = 1'b0;
        E     = 1'b0;
        In    = 3'd0;
        n     = 0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out", out2, 8'h00);
        end

        // Release in the low phase; count DIV_RATIO=6 phases over 24 edges
        rst_n  = 1'b1;
        hi6    = 0;
        rises6 = 0;
        prev6  = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (i == 0) chk("div2_first_edge", {7'd0, cb2}, 8'h01);
            if (cb6 === 1'b1) hi6++;
            if (prev6 === 1'b0 && cb6 === 1'b1) rises6++;
            prev6 = cb6;
        end
        chk("div6_high_cycles", 8'(hi6), 8'd12);
        chk("div6_periods", 8'(rises6), 8'd4);

        // Decoder sweep
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i));
            step();
            chk("sweep", out2, dec_ref(1'b1, 3'(i)));
        end

        // Enable gating
        drive(1'b0, 3'b101);
        step();
        chk("gate_off", out2, 8'h00);
        drive(1'b1, 3'b101);
        step();
        chk("gate_on", out2, 8'h20);

        // Mid-operation reset while DIV_RATIO=4 clock is high and Out=08
        drive(1'b1, 3'd3);
        step();
        waited = 0;
        while (cb4 !== 1'b1 && waited < 8) begin
            step();
            waited++;
        end
        chk("wait_div4_high", {7'd0, cb4}, 8'h01);
        chk("out_before_rst", out4, 8'h08);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_div4", {7'd0, cb4}, 8'h00);
        chk("async_rst_div2", {7'd0, cb2}, 8'h00);
        chk("async_rst_div6", {7'd0, cb6}, 8'h00);
        chk("async_rst_out", out4, REG_BUILD ? 8'h00 : 8'h08);
        n = 0;
        step();
        rst_n = 1'b1;
        step();
        chk("div4_no_toggle_1st", {7'd0, cb4}, 8'h00);
        step();
        chk("div4_toggle_2nd", {7'd0, cb4}, 8'h01);

        // Randomized run against the reference model
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom), 3'($urandom));
            step();
            chk("rand_out", out4, dec_ref(E, In));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
